// File: rtl/bpb_pkg.sv
// Shared definitions for the branch prediction buffer update controller.
// No ports: holds the branch opcodes, the pred/actual write encodings,
// the controller state enum and the default buffer index width.
package bpb_pkg;

    localparam int BPB_IDX_BITS = 4;

    // Opcodes occupy instruction bits [0:5] (MSB-first numbering).
    localparam logic [5:0] OP_BR0 = 6'b100010;
    localparam logic [5:0] OP_BR1 = 6'b100011;

    // {predicted, actual}: 01 sets the entry, 10 clears it, 00/11 hold it.
    localparam logic [1:0] PA_SET = 2'b01;
    localparam logic [1:0] PA_CLR = 2'b10;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/bpb_inflight_fifo.sv
// Ordered queue of predicted branches awaiting resolution.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clear      empties the queue; wins over a push in the same cycle
//   push, din  enqueue din at the tail
//   pop        dequeue the head (ignored while empty)
//   head       data at the head
//   count      occupancy, 0..DEPTH
module bpb_inflight_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    import bpb_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] hd;
    logic [PW-1:0] tl;
    logic          pop_ok;
    logic          push_ok;

    assign pop_ok  = pop && (count != '0);
    // A pop in the same cycle frees a slot, so a full queue may still accept.
    assign push_ok = push && !clear && ((count != FULL) || pop_ok);
    assign head    = mem[hd];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tl] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hd    <= '0;
            tl    <= '0;
            count <= '0;
        end else begin
            if (push_ok) tl <= tl + 1'b1;
            if (pop_ok)  hd <= hd + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bpb_update_ctrl.sv
// Branch prediction buffer update controller.
// After reset it sweeps every buffer entry to "taken", then tracks predicted
// branches from fetch, matches them with in-order resolve results and issues
// one buffer write per resolved branch. A mispredict empties the queue and
// raises a one-cycle flush request.
// Ports:
//   Clock, Reset                 clock, synchronous active-high reset
//   fetch_valid/instr/pred       fetched instruction and its prediction
//   fetch_ready                  a branch can be accepted this cycle
//   resolve_valid/taken          oldest in-flight branch resolved, outcome
//   upd_en/index/pred_actual     buffer write port
//   mispredict                   one-cycle pipeline flush request
//   init_busy                    initialisation sweep running
//   inflight                     queue occupancy
//   resolve_err                  sticky: resolve seen with empty queue
//   dbg_state                    controller state (INIT/RUN/FLUSH)
module bpb_update_ctrl
    import bpb_pkg::*;
#(
    parameter int IDX_BITS = BPB_IDX_BITS,
    parameter int DEPTH    = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   fetch_valid,
    input  logic [0:31]            fetch_instr,
    input  logic                   fetch_pred,
    output logic                   fetch_ready,
    input  logic                   resolve_valid,
    input  logic                   resolve_taken,
    output logic                   upd_en,
    output logic [0:IDX_BITS-1]    upd_index,
    output logic [0:1]             upd_pred_actual,
    output logic                   mispredict,
    output logic                   init_busy,
    output logic [0:$clog2(DEPTH)] inflight,
    output logic                   resolve_err,
    output logic [1:0]             dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t                state;
    logic [IDX_BITS-1:0]   sweep_cnt;
    logic [5:0]            opcode;
    logic                  is_branch;
    logic [IDX_BITS:0]     head;
    logic [IDX_BITS-1:0]   head_idx;
    logic                  head_pred;
    logic [CW-1:0]         count;
    logic                  do_resolve;
    logic                  mis;
    logic                  push;
    logic                  unused_bits;

    // Handshakes: a branch transfers on a cycle where fetch_valid and
    // fetch_ready are both high; non-branches are never held back.
    // resolve_valid has no ready: the result is consumed the cycle it is
    // presented in RUN (flagged via resolve_err if nothing is in flight).
    assign opcode      = fetch_instr[0:5];
    assign is_branch   = (opcode == OP_BR0) || (opcode == OP_BR1);
    assign unused_bits = ^fetch_instr[6:27];

    assign head_idx  = head[IDX_BITS:1];
    assign head_pred = head[0];

    assign do_resolve = (state == RUN) && resolve_valid && (count != '0);
    assign mis        = do_resolve && (head_pred != resolve_taken);
    // A resolving pop frees a slot, so a full queue still takes a branch.
    assign fetch_ready = !Reset && (state == RUN) && ((count != FULL) || resolve_valid);
    assign push        = fetch_valid && fetch_ready && is_branch && !mis;

    assign inflight  = count;
    assign dbg_state = state;

    bpb_inflight_fifo #(
        .DEPTH (DEPTH),
        .W     (IDX_BITS + 1)
    ) u_fifo (
        .clk   (Clock),
        .rst   (Reset),
        .clear (mis),
        .push  (push),
        .pop   (do_resolve),
        .din   ({fetch_instr[28:31], fetch_pred}),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state           <= INIT;
            sweep_cnt       <= '0;
            upd_en          <= 1'b0;
            upd_index       <= '0;
            upd_pred_actual <= 2'b00;
            mispredict      <= 1'b0;
            init_busy       <= 1'b1;
            resolve_err     <= 1'b0;
        end else begin
            upd_en     <= 1'b0;
            mispredict <= 1'b0;
            case (state)
                INIT: begin
                    upd_en          <= 1'b1;
                    upd_index       <= sweep_cnt;
                    upd_pred_actual <= PA_SET;
                    sweep_cnt       <= sweep_cnt + 1'b1;
                    if (sweep_cnt == {IDX_BITS{1'b1}}) begin
                        state     <= RUN;
                        init_busy <= 1'b0;
                    end
                end
                RUN: begin
                    if (resolve_valid) begin
                        if (count != '0) begin
                            upd_en          <= 1'b1;
                            upd_index       <= head_idx;
                            upd_pred_actual <= {head_pred, resolve_taken};
                            if (mis) begin
                                mispredict <= 1'b1;
                                state      <= FLUSH;
                            end
                        end else begin
                            resolve_err <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state <= RUN;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bpb_update_ctrl.sv
module tb_bpb_update_ctrl;

    logic        Clock;
    logic        Reset;
    logic        fetch_valid;
    logic [0:31] fetch_instr;
    logic        fetch_pred;
    logic        fetch_ready;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        upd_en;
    logic [0:3]  upd_index;
    logic [0:1]  upd_pred_actual;
    logic        mispredict;
    logic        init_busy;
    logic [0:2]  inflight;
    logic        resolve_err;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_on = 0;

    // Expected buffer write: {index, pred_actual, mispredict}
    logic [6:0] exp_q[$];

    bpb_update_ctrl dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .fetch_valid     (fetch_valid),
        .fetch_instr     (fetch_instr),
        .fetch_pred      (fetch_pred),
        .fetch_ready     (fetch_ready),
        .resolve_valid   (resolve_valid),
        .resolve_taken   (resolve_taken),
        .upd_en          (upd_en),
        .upd_index       (upd_index),
        .upd_pred_actual (upd_pred_actual),
        .mispredict      (mispredict),
        .init_busy       (init_busy),
        .inflight        (inflight),
        .resolve_err     (resolve_err),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic drive_br(input logic [5:0] op, input logic [3:0] idx, input logic pred);
        logic [31:0] w;
        w = {op, 22'd0, idx};
        fetch_valid = 1'b1;
        fetch_instr = w;
        fetch_pred  = pred;
    endtask

    task automatic idle_fetch();
        fetch_valid = 1'b0;
        fetch_instr = '0;
        fetch_pred  = 1'b0;
    endtask

    task automatic push_br(input logic [5:0] op, input logic [3:0] idx, input logic pred);
        drive_br(op, idx, pred);
        cycle();
        idle_fetch();
    endtask

    task automatic resolve(input logic taken, input logic [3:0] idx, input logic [1:0] pa, input logic mp);
        exp_q.push_back({idx, pa, mp});
        resolve_valid = 1'b1;
        resolve_taken = taken;
        cycle();
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
    endtask

    task automatic expect_sweep();
        for (int k = 0; k < 16; k++) begin
            logic [3:0] ki;
            ki = 4'(k);
            exp_q.push_back({ki, 2'b01, 1'b0});
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge Clock) begin
        if (mon_on) begin
            if (upd_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("upd_unexpected", {25'd0, upd_index, upd_pred_actual, mispredict}, 32'h0);
                end else begin
                    logic [6:0] e;
                    e = exp_q.pop_front();
                    chk("upd_idx_pa_mp", {25'd0, upd_index, upd_pred_actual, mispredict}, {25'd0, e});
                end
            end else begin
                chk("mispredict_idle", {31'd0, mispredict}, 32'd0);
                chk("upd_en_x", {31'd0, upd_en}, 32'd0);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        Reset         = 1'b1;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        idle_fetch();
        @(negedge Clock);
        cycle();
        cycle();
        mon_on = 1;

        // Reset state
        chk("rst_upd_en",      {31'd0, upd_en}, 32'd0);
        chk("rst_init_busy",   {31'd0, init_busy}, 32'd1);
        chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        chk("rst_inflight",    {29'd0, inflight}, 32'd0);
        chk("rst_resolve_err", {31'd0, resolve_err}, 32'd0);
        chk("rst_state",       {30'd0, dbg_state}, 32'd0);

        // Initialisation sweep: 16 writes of 01, indices 0..15
        expect_sweep();
        Reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("sweep_busy",  {31'd0, init_busy}, 32'd1);
            chk("sweep_ready", {31'd0, fetch_ready}, 32'd0);
            cycle();
        end
        chk("run_busy",     {31'd0, init_busy}, 32'd0);
        chk("run_ready",    {31'd0, fetch_ready}, 32'd1);
        chk("run_inflight", {29'd0, inflight}, 32'd0);
        chk("run_state",    {30'd0, dbg_state}, 32'd1);

        // Single branch, correct taken prediction -> 11
        push_br(6'b100010, 4'd10, 1'b1);
        chk("one_inflight", {29'd0, inflight}, 32'd1);
        resolve(1'b1, 4'd10, 2'b11, 1'b0);
        chk("one_drain", {29'd0, inflight}, 32'd0);

        // Non-branch instruction never pushes
        fetch_valid = 1'b1;
        fetch_instr = 32'h0000_0003;
        fetch_pred  = 1'b1;
        cycle();
        idle_fetch();
        chk("nonbr_inflight", {29'd0, inflight}, 32'd0);

        // Fill the queue, mixing both opcodes
        push_br(6'b100010, 4'd1, 1'b1);
        push_br(6'b100011, 4'd2, 1'b1);
        push_br(6'b100010, 4'd3, 1'b1);
        chk("fill3_ready", {31'd0, fetch_ready}, 32'd1);
        push_br(6'b100011, 4'd4, 1'b1);
        chk("full_ready",    {31'd0, fetch_ready}, 32'd0);
        chk("full_inflight", {29'd0, inflight}, 32'd4);
        push_br(6'b100010, 4'd9, 1'b1);   // not accepted while full
        chk("full_hold", {29'd0, inflight}, 32'd4);

        // Push concurrent with a correct resolve on a full queue
        drive_br(6'b100010, 4'd5, 1'b1);
        resolve_valid = 1'b1;
        #1;
        chk("full_resolve_ready", {31'd0, fetch_ready}, 32'd1);
        resolve_valid = 1'b0;
        resolve(1'b1, 4'd1, 2'b11, 1'b0);
        idle_fetch();
        chk("swap_inflight", {29'd0, inflight}, 32'd4);
        resolve(1'b1, 4'd2, 2'b11, 1'b0);
        resolve(1'b1, 4'd3, 2'b11, 1'b0);
        resolve(1'b1, 4'd4, 2'b11, 1'b0);
        resolve(1'b1, 4'd5, 2'b11, 1'b0);
        chk("drain_inflight", {29'd0, inflight}, 32'd0);

        // Mispredict on head 6 (pred 1, actual 0) with a push offered
        push_br(6'b100010, 4'd6, 1'b1);
        push_br(6'b100011, 4'd7, 1'b0);
        push_br(6'b100010, 4'd8, 1'b1);
        chk("q3_inflight", {29'd0, inflight}, 32'd3);
        drive_br(6'b100010, 4'd12, 1'b1);
        resolve(1'b0, 4'd6, 2'b10, 1'b1);
        idle_fetch();
        chk("mis_inflight", {29'd0, inflight}, 32'd0);
        chk("mis_ready",    {31'd0, fetch_ready}, 32'd0);
        chk("mis_state",    {30'd0, dbg_state}, 32'd2);
        cycle();
        chk("post_flush_ready",    {31'd0, fetch_ready}, 32'd1);
        chk("post_flush_inflight", {29'd0, inflight}, 32'd0);

        // Correct not-taken (00), then not-taken predicted but taken (01)
        push_br(6'b100011, 4'd13, 1'b0);
        resolve(1'b0, 4'd13, 2'b00, 1'b0);
        push_br(6'b100010, 4'd14, 1'b0);
        resolve(1'b1, 4'd14, 2'b01, 1'b1);
        cycle();
        chk("mis2_inflight", {29'd0, inflight}, 32'd0);

        // Resolve with nothing in flight: no write, sticky error
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        cycle();
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        chk("err_set", {31'd0, resolve_err}, 32'd1);
        cycle();
        cycle();
        chk("err_sticky", {31'd0, resolve_err}, 32'd1);

        // Reset mid-run with three branches in flight
        push_br(6'b100010, 4'd1, 1'b1);
        push_br(6'b100010, 4'd2, 1'b0);
        push_br(6'b100011, 4'd3, 1'b1);
        chk("pre_rst_inflight", {29'd0, inflight}, 32'd3);
        Reset = 1'b1;
        #1;
        chk("rst_hi_ready", {31'd0, fetch_ready}, 32'd0);
        cycle();
        chk("rerst_inflight", {29'd0, inflight}, 32'd0);
        chk("rerst_busy",     {31'd0, init_busy}, 32'd1);
        chk("rerst_err",      {31'd0, resolve_err}, 32'd0);
        expect_sweep();
        Reset = 1'b0;
        for (int i = 0; i < 16; i++) cycle();
        chk("rerun_ready", {31'd0, fetch_ready}, 32'd1);
        chk("rerun_busy",  {31'd0, init_busy}, 32'd0);
        cycle();
        cycle();

        chk("exp_q_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
